// File: rtl/instr_issue_pkg.sv
// instr_issue_pkg: widths, FSM encoding and field layout shared by the issue
// unit and the decoder. Instruction words are packed as {opcode, b, c}, opcode in the MSBs.
package instr_issue_pkg;
    localparam int OP_W    = 4;
    localparam int REG_W   = 6;
    localparam int INSTR_W = OP_W + 2 * REG_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;
endpackage

// File: rtl/instr_issue_fifo.sv
// instr_fifo: DEPTH x WIDTH circular queue with occupancy count and full/empty flags.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= wdata;
endmodule

// File: rtl/instr_issue.sv
// instr_issue: queues packed instructions and hands them to the decoder through
// an issue/hold/release handshake with a timeout on decoder acceptance.
module instr_issue
    import instr_issue_pkg::*;
#(
    parameter int OP_WIDTH    = OP_W,
    parameter int REG_WIDTH   = REG_W,
    parameter int INSTR_WIDTH = OP_WIDTH + 2 * REG_WIDTH,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_WIDTH-1:0]    in_opcode,
    input  logic [REG_WIDTH-1:0]   in_b,
    input  logic [REG_WIDTH-1:0]   in_c,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   triggered,
    input  logic                   indicate_busy,
    output logic                   check_busy,
    input  logic                   trigger,
    output logic                   timeout_err,
    output logic [$clog2(DEPTH):0] count
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t                 state;
    logic [TW-1:0]          tcnt;
    logic [INSTR_WIDTH-1:0] head;
    logic                   full, empty, pop, expire;

    assign expire   = state == ISSUE && !indicate_busy && tcnt == TW'(TIMEOUT - 1);
    assign pop      = expire || (state == RELEASE && trigger && !indicate_busy);
    assign in_ready = !full;

    instr_fifo #(.DEPTH(DEPTH), .WIDTH(INSTR_WIDTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (pop),
        .wdata (INSTR_WIDTH'({in_opcode, in_b, in_c})),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr       <= '0;
            triggered   <= 1'b0;
            check_busy  <= 1'b1;
            timeout_err <= 1'b0;
            tcnt        <= '0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    state     <= ISSUE;
                    instr     <= head;
                    triggered <= 1'b1;
                    tcnt      <= '0;
                end
                ISSUE: if (indicate_busy) begin
                    state     <= HOLD;
                    triggered <= 1'b0;
                    tcnt      <= '0;
                end else if (expire) begin
                    // Decoder never took the word: drop it and flag it permanently
                    state       <= IDLE;
                    triggered   <= 1'b0;
                    timeout_err <= 1'b1;
                    tcnt        <= '0;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
                HOLD: begin
                    state      <= RELEASE;
                    check_busy <= 1'b0;
                end
                RELEASE: if (trigger && !indicate_busy) begin
                    state      <= IDLE;
                    check_busy <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: randomized and directed stimulus with a queue-based reference
// model, a reactive decoder model and a scoreboard monitor.
module tb_instr_issue;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [3:0]  in_opcode = 0;
    logic [5:0]  in_b = 0, in_c = 0;
    logic [15:0] instr;
    logic        triggered;
    logic        indicate_busy = 0;
    logic        check_busy;
    logic        trigger = 0;
    logic        timeout_err;
    logic [2:0]  count;

    instr_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_opcode     (in_opcode),
        .in_b          (in_b),
        .in_c          (in_c),
        .instr         (instr),
        .triggered     (triggered),
        .indicate_busy (indicate_busy),
        .check_busy    (check_busy),
        .trigger       (trigger),
        .timeout_err   (timeout_err),
        .count         (count)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;
    logic [15:0] mq[$];
    logic [15:0] sb[$];
    bit          push_pend = 0, pop_dec = 0, pop_tmo = 0, exp_err = 0;
    logic [15:0] push_word = 0;
    int          rel_fix = -1, tmo_req = 0, tmo_done = 0;
    int          ds = 0, bdly = 0, rdly = 0, tcyc = 0;
    bit          tprev = 0;
    logic [15:0] last = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference queue: entries leave only on a completed handshake or a timeout
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            exp_err = 0;
        end else begin
            if ((pop_dec || pop_tmo) && mq.size() > 0) void'(mq.pop_front());
            if (pop_tmo) exp_err = 1;
            if (push_pend) mq.push_back(push_word);
        end
    end

    always @(negedge clk) begin
        pop_dec = 0;
        if (!rst_n) begin
            ds = 0;
            indicate_busy = 0;
            trigger = 0;
        end else begin
            case (ds)
                0: if (triggered) begin
                    if (tmo_done < tmo_req) begin
                        tmo_done++;
                        ds = 4;
                    end else if (bdly == 0) begin
                        indicate_busy = 1;
                        ds = 1;
                    end else bdly--;
                end
                1: begin
                    check("hold", {check_busy, triggered}, 2'b10);
                    rdly = rel_fix >= 0 ? rel_fix : $urandom_range(0, 3);
                    ds = 2;
                end
                2: begin
                    check("release", {check_busy, triggered}, 2'b00);
                    if (rdly == 0) begin
                        indicate_busy = 0;
                        trigger = 1;
                        pop_dec = 1;
                        ds = 3;
                    end else rdly--;
                end
                3: begin
                    check("idle_after_pop", {check_busy, triggered}, 2'b10);
                    trigger = 0;
                    bdly = $urandom_range(0, 3);
                    ds = 0;
                end
                default: if (!triggered) begin
                    bdly = $urandom_range(0, 3);
                    ds = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        pop_tmo = 0;
        if (!rst_n) begin
            tprev = 0;
            tcyc = 0;
            last = 0;
        end else begin
            check("count", 32'(count), 32'(mq.size()));
            check("timeout_err", 32'(timeout_err), 32'(exp_err));
            if (triggered) begin
                tcyc++;
                if (!tprev) begin
                    if (sb.size() == 0) check("issue_empty", 32'(sb.size()), 1);
                    else check("issue", 32'(instr), 32'(sb.pop_front()));
                    last = instr;
                end else check("instr_stable", 32'(instr), 32'(last));
                check("issue_len", 32'(tcyc <= TIMEOUT), 1);
                if (tcyc == TIMEOUT) pop_tmo = 1;
            end else begin
                tcyc = 0;
                check("instr_hold", 32'(instr), 32'(last));
            end
            tprev = triggered;
        end
    end

    task automatic push(input logic [3:0] op, input logic [5:0] b, input logic [5:0] c);
        logic [15:0] w;
        bit acc;
        w = {op, b, c};
        acc = mq.size() != DEPTH;
        check("in_ready", 32'(in_ready), 32'(acc));
        in_valid = 1;
        in_opcode = op;
        in_b = b;
        in_c = c;
        if (acc) begin
            sb.push_back(w);
            push_pend = 1;
            push_word = w;
        end
        @(negedge clk);
        in_valid = 0;
        push_pend = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        in_valid = 0;
        push_pend = 0;
        @(negedge clk);
        sb.delete();
        check("rst_count", 32'(count), 0);
        check("rst_check_busy", 32'(check_busy), 1);
        check("rst_triggered", 32'(triggered), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_instr", 32'(instr), 0);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(mq.size() == 0 && sb.size() == 0 && !triggered && check_busy && ds == 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 2000), 1);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        // Single instruction: issued one cycle after it lands
        push(4'hA, 6'h05, 6'h3F);
        @(negedge clk);
        check("first_triggered", 32'(triggered), 1);
        check("first_instr", 32'(instr), 32'h0000A17F);
        drain();
        check("first_count", 32'(count), 0);
        // Fill the queue and try a fifth push
        rel_fix = 3;
        for (int i = 0; i < 4; i++) push(4'(i + 1), 6'($urandom), 6'($urandom));
        check("full_in_ready", 32'(in_ready), 0);
        push(4'hF, 6'h2A, 6'h15);
        rel_fix = -1;
        drain();
        // Decoder stalls in RELEASE for 20 cycles
        rel_fix = 20;
        push(4'h3, 6'h11, 6'h22);
        drain();
        rel_fix = -1;
        // Decoder ignores one issue: timeout, discard, next entry still issues
        tmo_req++;
        push(4'h7, 6'h01, 6'h02);
        push(4'h8, 6'h03, 6'h04);
        drain();
        check("err_sticky", 32'(timeout_err), 1);
        push(4'h9, 6'h05, 6'h06);
        drain();
        check("err_still", 32'(timeout_err), 1);
        // Reset while the decoder is held in RELEASE with three entries queued
        rel_fix = 8;
        for (int i = 0; i < 3; i++) push(4'($urandom), 6'($urandom), 6'($urandom));
        for (int n = 0; n < 50 && check_busy; n++) @(negedge clk);
        check("pre_rst_release", 32'(check_busy), 0);
        check("pre_rst_count", 32'(count), 3);
        rel_fix = -1;
        do_reset();
        // Random traffic with occasional decoder timeouts
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) tmo_req++;
            if ($urandom_range(0, 9) < 6) push(4'($urandom), 6'($urandom), 6'($urandom));
            else @(negedge clk);
        end
        drain();
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
